arith_arb: RTL and testbench
============================

# arith_arb

Round-robin arbiter and two-stage pipeline controller sharing a single 8-bit `arith` add/subtract unit among `NREQ` requesters. Requesters present operands with a request/grant handshake. The winner's operands are registered into `arith`, and the result is registered and returned with the requester's id under a valid/ready handshake. The block sits between the client logic and the one `arith` instance, and owns all sequencing of that instance.

## Interface
- `NREQ`, default 2: number of requesters; legal values 2..4.
- `IDW`, default 2: width of the id field; must be at least clog2(NREQ).
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester request; held high until granted.
- `a_in`  in  8*NREQ: operand A, requester i at bits [8i+7:8i].
- `b_in`  in  8*NREQ: operand B, same packing as `a_in`.
- `sub_in`  in  NREQ: 1 = A-B, 0 = A+B.
- `gnt`  out  NREQ: one-hot grant, combinational; the operands are taken on the edge that ends the grant cycle.
- `rsp_valid`  out  1: result register holds a valid response.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  IDW: index of the requester that owns the response.
- `rsp_sum`  out  8: SUM from `arith`.
- `rsp_ov`  out  1: OV from `arith`.
- `ov_clr`  in  NREQ: per-requester clear of the overflow counter.
- `ov_cnt`  out  8*NREQ: per-requester overflow count, same packing as `a_in`.

## Operation
- **Stage 1 (operand register):**
  - Holds `op_valid`, A, B, SUB and id.
  - Drives `arith` .A/.B/.SUB combinationally.
- **Stage 2 (result register):**
  - Holds `rsp_valid`, `rsp_id`, and the captured SUM/OV.
- **Pipeline control:**
  - `adv = !rsp_valid | rsp_ready`.
  - `take = !op_valid | adv`.
- **Grant:**
  - At most one `gnt` bit is high, and only when `take` is 1 and at least one `req` bit is high.
  - Winner = first requesting index at or after the pointer `rr_ptr`, searching cyclically.
- **Pointer update:**
  - On a grant to index k, `rr_ptr` becomes (k+1) mod NREQ.
  - With no grant, `rr_ptr` holds.
- **Stage 1 update:**
  - On a grant, stage 1 loads the winner's operands and `op_valid` = 1.
  - Otherwise, if `take` is 1, `op_valid` = 0.
  - Otherwise stage 1 holds.
- **Stage 2 update:**
  - If `adv` is 1, stage 2 loads `rsp_valid` = `op_valid`, plus SUM, OV and id.
  - Otherwise stage 2 holds, and `arith` inputs stay stable.
- **Arithmetic:**
  - 8-bit two's complement; the result wraps.
  - OV is `arith`'s signed overflow, passed through unmodified.
- **Requester rules:**
  - A requester must not change its operands while `req` is high and it is not granted.
  - `req` low with `gnt` would be a violation; it cannot occur because grant is qualified by `req`.
- **Reset:**
  - `gnt` = 0 while `rst` is high.
  - On the reset edge: `rr_ptr` = 0, `op_valid` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 8'h00, `rsp_ov` = 0, and all `ov_cnt` = 0.
  - Reset mid-operation discards in-flight operations without producing a response.

## Timing
- **Latency:** grant in cycle N gives `rsp_valid` high in cycle N+2 if `rsp_ready` was high or `rsp_valid` was low in N+1.
- **Throughput:** one operation per cycle while `rsp_ready` = 1.
- **Backpressure:**
  - With `rsp_valid` = 1 and `rsp_ready` = 0, stage 2 holds.
  - If stage 1 is also full, `gnt` = 0 until a response is accepted.
  - The response is dropped or duplicated never; `rsp_*` stay constant while stalled.
- **Simultaneous events:** `rsp_ready` and a new grant in the same cycle means stage 2 takes stage 1 while stage 1 takes the new operands, both on one edge.
- **Fairness:** a requester that stays high is granted within NREQ grant cycles.

## Configuration
- Macro `ARITH_ARB_OVCNT_EN`.
- **Defined:**
  - `ov_cnt[i]` increments by 1 on each edge where `rsp_valid & rsp_ready & rsp_ov` holds and `rsp_id` = i.
  - The count saturates at 8'hFF.
  - `ov_clr[i]` sets the count to 0; clear wins over a same-cycle increment.
- **Undefined:**
  - The ports remain present.
  - `ov_cnt` is tied to 0, `ov_clr` is ignored, and no counter flops exist.

## Structure
- **Package `arith_arb_pkg`:**
  - `ARITH_W` = 8.
  - `MAX_NREQ` = 4.
  - Typedef `arith_op_t` {a, b, sub, id}.
  - Typedef `arith_rsp_t` {sum, ov, id}.
- **Sub-module `rr_pick`:** combinational one-hot cyclic priority picker taking `req` and `rr_ptr`, producing `gnt`; it is reusable.
- **`arith`:** instantiated once, unmodified.

## Test plan
- **Reset mid-stream:** `rst` held for 2 cycles during traffic → all outputs at their reset values, no response after release until a new grant.
- **Single add:** req0 only, A=8'hFF, B=8'hF0, SUB=0 → gnt=01 in cycle N; cycle N+2 `rsp_valid`=1, id=0, sum=8'hEF, ov=0.
- **Contention with backpressure:** req0 A=8'h7F B=8'h01 add and req1 A=8'h80 B=8'h01 sub both held, `rsp_ready`=1 → grants 01 then 10; responses (0, 8'h80, ov=1) then (1, 8'h7F, ov=1).
- **Stall:** `rsp_ready`=0 with 3 back-to-back ops → two responses buffered, `gnt`=0 on the third; the first response holds stable; on `rsp_ready`=1 all three emerge in order.
- **Fairness:** both requesters high for 8 cycles → grants alternate 01,10,01,…
- **Overflow counter (with `ARITH_ARB_OVCNT_EN`):**
  - Overflowing op 8'h7F+8'h01 on req0 accepted 300 times → `ov_cnt[0]`=8'hFF.
  - `ov_clr[0]` in the same cycle as an increment → 8'h00.

Source files
------------

// File: rtl/arith_arb_pkg.sv
// arith_arb_pkg: shared widths, operand/response record types and small
// helpers for the arith_arb arbiter/pipeline controller.
package arith_arb_pkg;

    localparam int ARITH_W  = 8;
    localparam int MAX_NREQ = 4;
    // Width of the id field carried inside the records; covers MAX_NREQ.
    localparam int ID_W     = 2;
    // Width of the round-robin pointer; covers MAX_NREQ.
    localparam int PTR_W    = 2;

    // Operand record held in stage 1.
    typedef struct packed {
        logic [ARITH_W-1:0] a;
        logic [ARITH_W-1:0] b;
        logic               sub;
        logic [ID_W-1:0]    id;
    } arith_op_t;

    // Result record held in stage 2.
    typedef struct packed {
        logic [ARITH_W-1:0] sum;
        logic               ov;
        logic [ID_W-1:0]    id;
    } arith_rsp_t;

    // Saturating 8-bit increment used by the overflow counters.
    function automatic logic [ARITH_W-1:0] sat_inc(input logic [ARITH_W-1:0] v);
        logic [ARITH_W-1:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Cyclic successor of a pointer value for n requesters.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p, input int n);
        logic [PTR_W-1:0] r;
        if (int'(p) >= n - 1) begin
            r = '0;
        end else begin
            r = p + 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arith.sv
// arith: 8-bit two's complement adder/subtractor with signed overflow flag.
// Shared unit; operands are driven straight from the arbiter's stage 1.
module arith (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       SUB,
    output logic [7:0] SUM,
    output logic       OV
);

    logic [7:0] b_eff_s;

    // Subtraction is A + ~B + 1; the carry-in comes from SUB.
    always_comb begin
        b_eff_s = SUB ? ~B : B;
        SUM     = A + b_eff_s + {7'd0, SUB};
        OV      = (A[7] == b_eff_s[7]) && (SUM[7] != A[7]);
    end

endmodule

// File: rtl/arith_arb_rr_pick.sv
// rr_pick: combinational one-hot cyclic priority picker. The winner is the
// first requesting index at or after ptr_i, wrapping around; nothing is
// picked while en_i is low.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] gnt_s;
    logic         found_s;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        for (int off = 0; off < N; off++) begin
            int idx_v;
            idx_v = (int'(ptr_i) + off) % N;
            if (en_i && !found_s && req_i[idx_v]) begin
                gnt_s[idx_v] = 1'b1;
                found_s      = 1'b1;
            end else begin
            end
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/arith_arb.sv
// arith_arb: round-robin arbiter and two-stage pipeline controller in front
// of a single shared arith unit.
//   stage 1: operand register (drives arith inputs)
//   stage 2: result register (response under valid/ready)
// Optional feature macro: ARITH_ARB_OVCNT_EN enables the per-requester
// saturating overflow counters; without it ov_cnt reads zero and ov_clr
// is ignored.
module arith_arb
    import arith_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [ARITH_W*NREQ-1:0] a_in,
    input  logic [ARITH_W*NREQ-1:0] b_in,
    input  logic [NREQ-1:0]         sub_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ARITH_W-1:0]      rsp_sum,
    output logic                    rsp_ov,
    input  logic [NREQ-1:0]         ov_clr,
    output logic [ARITH_W*NREQ-1:0] ov_cnt
);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    arith_op_t          op_q, op_d;
    logic               op_valid_q, op_valid_d;
    arith_rsp_t         rsp_q, rsp_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic               adv_s;
    logic               take_s;
    logic [NREQ-1:0]    gnt_s;
    logic               grant_s;
    logic [PTR_W-1:0]   win_s;
    arith_op_t          sel_op_s;
    logic [ARITH_W-1:0] sum_s;
    logic               ov_s;

    // Pipeline flow control: stage 2 can move when empty or being drained,
    // stage 1 can accept when empty or moving into stage 2.
    always_comb begin
        adv_s  = !rsp_valid_q || rsp_ready;
        take_s = !op_valid_q || adv_s;
    end

    rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .en_i  (take_s && !rst),
        .gnt_o (gnt_s)
    );

    assign gnt     = gnt_s;
    assign grant_s = |gnt_s;

    // Encode the winner and mux its operands into a stage-1 record.
    always_comb begin
        win_s    = '0;
        sel_op_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                win_s        = PTR_W'(i);
                sel_op_s.a   = a_in[i*ARITH_W +: ARITH_W];
                sel_op_s.b   = b_in[i*ARITH_W +: ARITH_W];
                sel_op_s.sub = sub_in[i];
                sel_op_s.id  = ID_W'(i);
            end else begin
            end
        end
    end

    // The one shared arithmetic unit, fed from stage 1.
    arith u_arith (
        .A   (op_q.a),
        .B   (op_q.b),
        .SUB (op_q.sub),
        .SUM (sum_s),
        .OV  (ov_s)
    );

    // Next state for the pointer and stage 1.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        op_d       = op_q;
        op_valid_d = op_valid_q;
        if (grant_s) begin
            rr_ptr_d   = ptr_next(win_s, NREQ);
            op_d       = sel_op_s;
            op_valid_d = 1'b1;
        end else if (take_s) begin
            op_valid_d = 1'b0;
        end else begin
        end
    end

    // Next state for stage 2; holding keeps rsp_* stable under backpressure.
    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (adv_s) begin
            rsp_valid_d = op_valid_q;
            rsp_d.sum   = sum_s;
            rsp_d.ov    = ov_s;
            rsp_d.id    = op_q.id;
        end else begin
        end
    end

    // Pipeline and pointer registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            op_valid_q  <= op_valid_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = IDW'(rsp_q.id);
    assign rsp_sum   = rsp_q.sum;
    assign rsp_ov    = rsp_q.ov;

`ifdef ARITH_ARB_OVCNT_EN
    logic [ARITH_W-1:0] ov_cnt_q [NREQ];
    logic [ARITH_W-1:0] ov_cnt_d [NREQ];

    // Count accepted overflowing responses per owner; clear has priority.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ov_cnt_d[i] = ov_cnt_q[i];
            if (ov_clr[i]) begin
                ov_cnt_d[i] = 8'h00;
            end else if (rsp_valid_q && rsp_ready && rsp_q.ov && (rsp_q.id == ID_W'(i))) begin
                ov_cnt_d[i] = sat_inc(ov_cnt_q[i]);
            end else begin
            end
        end
    end

    // Overflow counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                ov_cnt_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                ov_cnt_q[i] <= ov_cnt_d[i];
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        ov_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            ov_cnt[i*ARITH_W +: ARITH_W] = ov_cnt_q[i];
        end
    end
`else
    // Counters not built: constant zero, clear inputs have no effect.
    logic unused_ov_clr_s;
    assign unused_ov_clr_s = ^ov_clr;
    assign ov_cnt          = '0;
`endif

endmodule

// File: tb/tb_arith_arb.sv
// tb_arith_arb: randomized and directed stimulus for arith_arb, checked each
// cycle against a queue-based reference model of the arbiter and pipeline.
`timescale 1ns/1ps
module tb_arith_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   a_in;
    logic [8*NREQ-1:0]   b_in;
    logic [NREQ-1:0]     sub_in;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_sum;
    logic                rsp_ov;
    logic [NREQ-1:0]     ov_clr;
    logic [8*NREQ-1:0]   ov_cnt;

    arith_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ov    (rsp_ov),
        .ov_clr    (ov_clr),
        .ov_cnt    (ov_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int id;
        int sum;
        int ov;
    } mop_t;

    mop_t            inflight[$];   // accepted ops, oldest first
    bit              head_out;      // oldest op is currently presented
    int              ptr;
    int              cnt [NREQ];
    int              n_tests;
    int              n_fail;
    logic [NREQ-1:0] gnt_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of requester k's current operands, from signed integer maths.
    function automatic mop_t make_op(input int k);
        mop_t m;
        int   a;
        int   b;
        int   r;
        a = int'(a_in[8*k +: 8]);
        b = int'(b_in[8*k +: 8]);
        if (a > 127) a = a - 256;
        if (b > 127) b = b - 256;
        r     = sub_in[k] ? (a - b) : (a + b);
        m.id  = k;
        m.sum = r & 255;
        m.ov  = (r > 127 || r < -128) ? 1 : 0;
        return m;
    endfunction

    // Index that must be granted now, or -1.
    function automatic int model_pick();
        int nin;
        bit adv;
        if (rst) return -1;
        nin = inflight.size() - int'(head_out);
        adv = !head_out || rsp_ready;
        if (!(nin == 0 || adv)) return -1;
        for (int off = 0; off < NREQ; off++) begin
            int k;
            k = (ptr + off) % NREQ;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int              k;
        logic [NREQ-1:0] eg;
        k  = model_pick();
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(head_out));
        if (head_out) begin
            check("rsp_id", 32'(rsp_id), 32'(inflight[0].id));
            check("rsp_sum", 32'(rsp_sum), 32'(inflight[0].sum));
            check("rsp_ov", 32'(rsp_ov), 32'(inflight[0].ov));
        end
        for (int i = 0; i < NREQ; i++) begin
`ifdef ARITH_ARB_OVCNT_EN
            check("ov_cnt", 32'(ov_cnt[8*i +: 8]), 32'(cnt[i]));
`else
            check("ov_cnt_zero", 32'(ov_cnt[8*i +: 8]), 32'd0);
`endif
        end
        gnt_seen = gnt;
    end

    // Model state update on the same edge as the DUT.
    always @(posedge clk) begin
        int k;
        int nin;
        bit adv;
        k = model_pick();
        if (rst) begin
            inflight.delete();
            head_out = 1'b0;
            ptr      = 0;
            for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ov_clr[i]) cnt[i] = 0;
                else if (head_out && rsp_ready && inflight[0].ov == 1 && inflight[0].id == i)
                    cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
            end
            nin = inflight.size() - int'(head_out);
            adv = !head_out || rsp_ready;
            if (head_out && rsp_ready) begin
                inflight.delete(0);
                head_out = 1'b0;
            end
            if (adv && nin > 0) head_out = 1'b1;
            if (k >= 0) begin
                inflight.push_back(make_op(k));
                ptr = (k + 1) % NREQ;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (gnt_seen[i]) req[i] = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
        req[i]          = 1'b1;
        a_in[8*i +: 8]  = a;
        b_in[8*i +: 8]  = b;
        sub_in[i]       = s;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && ($urandom_range(3) != 0))
                    set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
            rsp_ready = ($urandom_range(2) != 0);
            ov_clr    = ($urandom_range(7) == 0) ? NREQ'($urandom) : '0;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        sub_in    = '0;
        rsp_ready = 1'b1;
        ov_clr    = '0;
        gnt_seen  = '0;

        // Reset state, with a request pending that must not be granted.
        tick();
        set_op(0, 8'h12, 8'h34, 1'b0);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'h00);
        check("rst_rsp_ov", 32'(rsp_ov), 32'd0);
        check("rst_ov_cnt", 32'(ov_cnt), 32'd0);
        req = '0;
        rst = 1'b0;

        // Contention: both requesters, pointer at 0.
        tick();
        set_op(0, 8'h7F, 8'h01, 1'b0);
        set_op(1, 8'h80, 8'h01, 1'b1);
        #1; check("cont_gnt0", 32'(gnt), 32'b01);
        tick();
        #1; check("cont_gnt1", 32'(gnt), 32'b10);
        tick();
        #1; check("cont_r0_valid", 32'(rsp_valid), 32'd1);
        check("cont_r0_id", 32'(rsp_id), 32'd0);
        check("cont_r0_sum", 32'(rsp_sum), 32'h80);
        check("cont_r0_ov", 32'(rsp_ov), 32'd1);
        tick();
        #1; check("cont_r1_id", 32'(rsp_id), 32'd1);
        check("cont_r1_sum", 32'(rsp_sum), 32'h7F);
        check("cont_r1_ov", 32'(rsp_ov), 32'd1);

        // Single add, two-cycle latency.
        tick();
        set_op(0, 8'hFF, 8'hF0, 1'b0);
        #1; check("add_gnt", 32'(gnt), 32'b01);
        tick();
        tick();
        #1; check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_id", 32'(rsp_id), 32'd0);
        check("add_sum", 32'(rsp_sum), 32'hEF);
        check("add_ov", 32'(rsp_ov), 32'd0);

        // Stall: three back-to-back ops with the consumer not ready.
        tick();
        rsp_ready = 1'b0;
        set_op(0, 8'h01, 8'h02, 1'b0);
        #1; check("stall_gnt_a", 32'(gnt), 32'b01);
        tick();
        set_op(0, 8'h10, 8'h20, 1'b0);
        #1; check("stall_gnt_b", 32'(gnt), 32'b01);
        tick();
        set_op(0, 8'h05, 8'h07, 1'b1);
        #1; check("stall_gnt_blk", 32'(gnt), 32'd0);
        check("stall_hold_sum", 32'(rsp_sum), 32'h03);
        tick();
        #1; check("stall_gnt_blk2", 32'(gnt), 32'd0);
        check("stall_hold_valid", 32'(rsp_valid), 32'd1);
        check("stall_hold_sum2", 32'(rsp_sum), 32'h03);
        rsp_ready = 1'b1;
        #1; check("stall_gnt_c", 32'(gnt), 32'b01);
        tick();
        #1; check("stall_out_b", 32'(rsp_sum), 32'h30);
        tick();
        #1; check("stall_out_c", 32'(rsp_sum), 32'hFE);
        check("stall_out_c_ov", 32'(rsp_ov), 32'd0);

        // Fairness: both held high; pointer sits at 1 after the stall test.
        tick();
        set_op(0, 8'h01, 8'h01, 1'b0);
        set_op(1, 8'h02, 8'h02, 1'b0);
        for (int c = 0; c < 8; c++) begin
            #1; check("fair_gnt", 32'(gnt), (c % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            for (int i = 0; i < NREQ; i++)
                if (!req[i]) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Random traffic, then reset in the middle of it.
        rand_cycles(600);
        rst = 1'b1;
        tick();
        tick();
        #1; check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'h00);
        check("mid_rst_ov", 32'(rsp_ov), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        rst       = 1'b0;
        req       = '0;
        ov_clr    = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1; check("post_rst_idle", 32'(rsp_valid), 32'd0);
        end
        rand_cycles(600);

`ifdef ARITH_ARB_OVCNT_EN
        // Saturating overflow count, then clear against an increment.
        rst = 1'b1;
        req = '0;
        ov_clr = '0;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        begin
            int granted;
            granted = 0;
            while (granted < 300) begin
                tick();
                if (gnt_seen[0]) granted++;
                if (granted < 300 && !req[0]) set_op(0, 8'h7F, 8'h01, 1'b0);
            end
        end
        req = '0;
        repeat (4) tick();
        #1; check("ovcnt_sat", 32'(ov_cnt[7:0]), 32'hFF);
        set_op(0, 8'h7F, 8'h01, 1'b0);
        tick();
        set_op(0, 8'h7F, 8'h01, 1'b0);
        tick();
        #1; check("ovclr_pre_valid", 32'(rsp_valid), 32'd1);
        ov_clr = 2'b01;
        tick();
        ov_clr = '0;
        req = '0;
        #1; check("ovclr_wins", 32'(ov_cnt[7:0]), 32'h00);
        repeat (3) tick();
`endif

        req = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
